// File: rtl/pwm_pkg.sv
// pwm_pkg: FSM state type, PWM register map and default bus timeout shared by the config master
package pwm_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} state_t;
  localparam logic [15:0] ADR_CTRL   = 16'd0;
  localparam logic [15:0] ADR_DIV    = 16'd2;
  localparam logic [15:0] ADR_PERIOD = 16'd4;
  localparam logic [15:0] ADR_DC     = 16'd6;
  localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/wb_cmd_fifo.sv
// wb_cmd_fifo: show-ahead sync FIFO (clk, rst, push/din, pop/dout head, full, empty); overflow/underflow ignored
module wb_cmd_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/wb_cfg_master.sv
// wb_cfg_master: queued cmd (i_cmd_*) -> single-cycle Wishbone master (o_wb_*/i_wb_*) with timeout, one o_rsp_* pulse per command
module wb_cfg_master
  import pwm_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_we,
  input  logic [ADDR_W-1:0] i_cmd_adr,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_busy,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_adr,
  output logic [DATA_W-1:0] o_wb_data,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_wb_ack
);
  localparam int CW = $clog2(TIMEOUT);
  localparam int FW = 1 + ADDR_W + DATA_W;
  state_t state, state_nxt;
  logic [FW-1:0] head;
  logic [CW-1:0] cnt;
  logic full, empty, pop, to, done;
  wb_cmd_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .push(i_cmd_valid),
    .pop(pop),
    .din({i_cmd_we, i_cmd_adr, i_cmd_data}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge i_clk)
    state <= i_rst ? ST_IDLE : state_nxt;
  always_comb
    state_nxt = state == ST_IDLE ? (empty ? ST_IDLE : ST_REQ) :
                state == ST_REQ  ? (done ? ST_RSP : ST_REQ) : ST_IDLE;
  // ack beats timeout on the same edge: done covers both, err only when ack is absent
  always_comb begin
    pop = state == ST_IDLE && !empty;
    to = cnt == CW'(TIMEOUT - 1);
    done = state == ST_REQ && (i_wb_ack || to);
    o_cmd_ready = !full;
    o_busy = !empty || state != ST_IDLE;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      o_wb_cyc <= 1'b0;
      o_wb_we <= 1'b0;
      o_wb_adr <= '0;
      o_wb_data <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_err <= 1'b0;
      o_rsp_data <= '0;
      cnt <= '0;
    end else begin
      o_rsp_valid <= done;
      o_rsp_err <= done && !i_wb_ack;
      o_rsp_data <= (done && i_wb_ack && !o_wb_we) ? i_wb_data : '0;
      if (pop) begin
        {o_wb_we, o_wb_adr, o_wb_data} <= head;
        o_wb_cyc <= 1'b1;
        cnt <= '0;
      end else begin
        if (done) o_wb_cyc <= 1'b0;
        if (state == ST_REQ && !to) cnt <= cnt + 1'b1;
      end
    end
  assign o_wb_stb = o_wb_cyc;
endmodule
